nes_multipad: RTL and testbench
===============================

NES_MULTIPAD -- requirements
Module: nes_multipad

Interface
REQ-001 Parameter N_PADS, default 2: number of controllers sharing latch/clock, range 1..4.
REQ-002 Parameter BITS, default 8: bits per pad (8 = NES, 16 = SNES), range 2..16.
REQ-003 Parameter TICK_DIV, default 300: inputclk cycles per half-bit tick (6 us at 50 MHz), minimum 2.
REQ-004 Parameter POLL_GAP, default 2778: idle ticks between frames (~60 Hz), minimum 1.
REQ-005 inputclk  in  1  system clock, single clock domain.
REQ-006 reset_b  in  1  reset, asynchronous, active-low.
REQ-007 data  in  N_PADS  serial data per pad, active-low (0 = pressed), asynchronous.
REQ-008 poll_en  in  1  polling enable.
REQ-009 clklatch  out  1  shared latch strobe to all pads.
REQ-010 clkout  out  1  shared shift clock to all pads.
REQ-011 buttons  out  N_PADS*BITS  debounced-by-frame state, 1 = pressed, pad p bit b at index p*BITS+b.
REQ-012 pressed  out  N_PADS*BITS  one-cycle strobe per button, 0->1 transition.
REQ-013 released  out  N_PADS*BITS  one-cycle strobe per button, 1->0 transition.
REQ-014 frame_valid  out  1  one-cycle strobe when buttons update.

Function
REQ-015 Prescaler counts 0..TICK_DIV-1; tick asserts for one cycle at TICK_DIV-1, then wraps to 0.
REQ-016 Prescaler resets to 0 on every state change, so each state lasts whole ticks.
REQ-017 data bits pass through a 2-flop synchroniser; all sampling uses synchronised values.
REQ-018 FSM states: IDLE, LATCH, READ, SHIFT, UPDATE, GAP; all transitions occur on tick except UPDATE.
REQ-019 IDLE: outputs low; if poll_en=1 on tick -> LATCH.
REQ-020 LATCH: clklatch=1 for exactly 2 ticks (2*TICK_DIV cycles); bit index cleared -> READ.
REQ-021 READ: clkout=0 for 1 tick; on its tick sample every pad's data into shift register bit (index); if index=BITS-1 -> UPDATE, else -> SHIFT.
REQ-022 SHIFT: clkout=1 for 1 tick; index increments -> READ; BITS-1 clkout pulses per frame.
REQ-023 UPDATE (one cycle): buttons <= ~shift; pressed = new & ~old; released = ~new & old; frame_valid=1; -> GAP.
REQ-024 pressed, released and frame_valid are 0 in every cycle except UPDATE's output cycle.
REQ-025 Latency: buttons, strobes and frame_valid appear one inputclk cycle after the final READ sample.
REQ-026 GAP: count POLL_GAP ticks; then -> LATCH if poll_en=1, else IDLE.
REQ-027 A poll_en drop mid-frame has no effect until the frame completes.
REQ-028 An unplugged pad (data floating high) reads as all-released; no error flag.
REQ-029 Simultaneous press/release of different buttons in one frame strobes both vectors in the same cycle.
REQ-030 clklatch and clkout are driven directly from registers (glitch-free).

Reset
REQ-031 reset_b=0 asynchronously forces: state IDLE, prescaler 0, index 0, shift 0, synchronisers 1 (released), clklatch=0, clkout=0, buttons=0, pressed=0, released=0, frame_valid=0.
REQ-032 A reset mid-frame discards the partial frame; the first frame after release is compared against buttons=0.

Structure
REQ-033 Package nes_pkg holds the state enum, button index constants (BTN_A=0, B=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7), and default parameter constants.
REQ-034 Prescaler is sub-module nes_tick_gen (parameter TICK_DIV; ports inputclk, reset_b, clear, tick).

Verification (N_PADS=2, BITS=8, TICK_DIV=4, POLL_GAP=3, behavioural pad models)
REQ-035 Reset with reset_b=0 mid-LATCH -> clklatch=0 and all outputs 0 within the same cycle; after release, IDLE and latch high 8 cycles.
REQ-036 Pad0 serial 0,1,1,1,1,1,1,0 -> buttons[7:0]=8'h81, pressed[7:0]=8'h81, frame_valid high for 1 cycle.
REQ-037 Repeat the same frame -> buttons held at 8'h81, pressed=0, released=0.
REQ-038 Pad0 releases A, pad1 presses Up -> released[0]=1 and pressed[12]=1 in the same cycle.
REQ-039 Timing check -> clklatch 8 cycles, 7 clkout pulses 4 cycles high each, frame period (2+8+7+3)*4+1 = 81 cycles.
REQ-040 Reset during READ of bit 3, then pad0 sends 8'h81 pattern -> first frame buttons[7:0]=8'h81, pressed[7:0]=8'h81.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES/SNES multi-controller poller:
// FSM state encoding, standard button bit positions and default timing.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_READ,
    ST_SHIFT,
    ST_UPDATE,
    ST_GAP
  } nes_state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int DEF_N_PADS   = 2;
  localparam int DEF_BITS     = 8;
  localparam int DEF_TICK_DIV = 300;
  localparam int DEF_POLL_GAP = 2778;

  // Latch strobe width in half-bit ticks.
  localparam int LATCH_TICKS = 2;

endpackage

// File: rtl/nes_tick_gen.sv
// Half-bit tick prescaler: one-cycle tick every TICK_DIV clocks, restartable
// so that every FSM state spans a whole number of ticks.
module nes_tick_gen #(
  parameter int TICK_DIV = 300
) (
  input  logic inputclk,
  input  logic reset_b,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/nes_multipad.sv
// Polls up to four NES/SNES pads on a shared latch/clock pair and reports
// the per-frame button state plus one-cycle press/release strobes.
module nes_multipad
  import nes_pkg::*;
#(
  parameter int N_PADS   = DEF_N_PADS,
  parameter int BITS     = DEF_BITS,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int POLL_GAP = DEF_POLL_GAP
) (
  input  logic                     inputclk,
  input  logic                     reset_b,
  input  logic [N_PADS-1:0]        data,
  input  logic                     poll_en,
  output logic                     clklatch,
  output logic                     clkout,
  output logic [N_PADS*BITS-1:0]   buttons,
  output logic [N_PADS*BITS-1:0]   pressed,
  output logic [N_PADS*BITS-1:0]   released,
  output logic                     frame_valid
);

  localparam int IW = $clog2(BITS);
  localparam int GW = $clog2(POLL_GAP + 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(BITS - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);
  localparam logic [GW-1:0] LATCH_LAST = GW'(LATCH_TICKS - 1);

  nes_state_e state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [GW-1:0] tcnt, tcnt_n;
  logic tick, tick_clr, sample, upd;

  logic [N_PADS-1:0] sync_p0, sync_p1;
  logic [N_PADS*BITS-1:0] shift;

  nes_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .inputclk (inputclk),
    .reset_b  (reset_b),
    .clear    (tick_clr),
    .tick     (tick)
  );

  // Stage p0/p1: two-flop synchroniser, idles at "released".
  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= data;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tcnt_n  = tcnt;
    sample  = 1'b0;
    upd     = 1'b0;
    case (state)
      ST_IDLE: if (tick && poll_en) state_n = ST_LATCH;
      ST_LATCH: begin
        idx_n = '0;
        if (tick) begin
          if (tcnt == LATCH_LAST) state_n = ST_READ;
          else                    tcnt_n  = tcnt + 1'b1;
        end
      end
      ST_READ: if (tick) begin
        sample  = 1'b1;
        state_n = (idx == IDX_LAST) ? ST_UPDATE : ST_SHIFT;
      end
      ST_SHIFT: if (tick) begin
        idx_n   = idx + 1'b1;
        state_n = ST_READ;
      end
      ST_UPDATE: begin
        upd     = 1'b1;
        state_n = ST_GAP;
      end
      ST_GAP: if (tick) begin
        if (tcnt == GAP_LAST) state_n = poll_en ? ST_LATCH : ST_IDLE;
        else                  tcnt_n  = tcnt + 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    // The UPDATE->GAP step is off-tick, so restarting the prescaler here
    // keeps GAP aligned to whole ticks.
    tick_clr = (state_n != state);
    if (tick_clr) tcnt_n = '0;
  end

  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= ST_IDLE;
      idx      <= '0;
      tcnt     <= '0;
      clklatch <= 1'b0;
      clkout   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tcnt     <= tcnt_n;
      clklatch <= (state_n == ST_LATCH);
      clkout   <= (state_n == ST_SHIFT);
    end
  end

  // Stage p2: capture each pad's current bit at the end of READ.
  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      shift <= '0;
    end else begin
      for (int p = 0; p < N_PADS; p++) begin
        for (int b = 0; b < BITS; b++) begin
          if (sample && idx == IW'(b)) shift[p*BITS + b] <= sync_p1[p];
        end
      end
    end
  end

  // Output stage: pads are active-low, so invert into the published state.
  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      buttons     <= '0;
      pressed     <= '0;
      released    <= '0;
      frame_valid <= 1'b0;
    end else if (upd) begin
      buttons     <= ~shift;
      pressed     <= ~shift & ~buttons;
      released    <= shift & buttons;
      frame_valid <= 1'b1;
    end else begin
      pressed     <= '0;
      released    <= '0;
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nes_multipad.sv
// Bench for nes_multipad: behavioural shift-register pads, random button
// frames and a frame-level model of buttons/pressed/released.
module tb_nes_multipad;

  localparam int NP = 2;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic poll_en = 1'b0;
  logic [NP-1:0] data;
  logic clklatch, clkout, frame_valid;
  logic [NP*NB-1:0] buttons, pressed, released;

  always #5 clk = ~clk;

  nes_multipad #(.N_PADS(NP), .BITS(NB), .TICK_DIV(4), .POLL_GAP(3)) dut (
    .inputclk    (clk),
    .reset_b     (rst_n),
    .data        (data),
    .poll_en     (poll_en),
    .clklatch    (clklatch),
    .clkout      (clkout),
    .buttons     (buttons),
    .pressed     (pressed),
    .released    (released),
    .frame_valid (frame_valid)
  );

  // Pads: 1 in pat = held down. Latch loads, each clkout rise advances.
  logic [NB-1:0] pat [NP];
  int pidx = 0;

  always @(posedge clklatch or posedge clkout) begin
    if (clklatch) pidx = 0;
    else          pidx = pidx + 1;
  end

  always_comb begin
    data = '1;
    for (int p = 0; p < NP; p++) data[p] = (pidx < NB) ? ~pat[p][pidx] : 1'b1;
  end

  // Waveform monitor, gathered per frame (frame_valid to frame_valid).
  int cyc_cnt = 0, latch_cyc = 0, ck_cyc = 0, ck_rise = 0, ck_run = 0;
  int period_s = 0, latch_s = 0, ckcyc_s = 0, ckrise_s = 0;
  int pulse_bad = 0, strobe_bad = 0;
  logic ck_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc_cnt = 0; latch_cyc = 0; ck_cyc = 0; ck_rise = 0; ck_run = 0;
      ck_prev = 1'b0;
    end else begin
      cyc_cnt++;
      if (clklatch) latch_cyc++;
      if (clkout) begin
        ck_cyc++;
        ck_run++;
        if (!ck_prev) ck_rise++;
      end else begin
        if (ck_prev && ck_run != 4) pulse_bad++;
        ck_run = 0;
      end
      ck_prev = clkout;
      if (!frame_valid && (pressed != '0 || released != '0)) strobe_bad++;
      if (frame_valid) begin
        period_s = cyc_cnt; latch_s = latch_cyc; ckcyc_s = ck_cyc; ckrise_s = ck_rise;
        cyc_cnt = 0; latch_cyc = 0; ck_cyc = 0; ck_rise = 0;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [NP*NB-1:0] model_btn = '0;
  logic [NP*NB-1:0] last_pr, last_rl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_latch(input string tag);
    int n = 0;
    while (clklatch !== 1'b1 && n < 400) begin step(); n++; end
    chk({tag, "_latch_timeout"}, 32'(n >= 400), 0);
  endtask

  task automatic expect_frame(input string tag);
    logic [NP*NB-1:0] nw, ep, er;
    int n = 0;
    while (frame_valid !== 1'b1 && n < 400) begin step(); n++; end
    chk({tag, "_timeout"}, 32'(n >= 400), 0);
    nw = {pat[1], pat[0]};
    ep = nw & ~model_btn;
    er = ~nw & model_btn;
    model_btn = nw;
    last_pr = pressed;
    last_rl = released;
    chk({tag, "_buttons"}, 32'(buttons), 32'(nw));
    chk({tag, "_pressed"}, 32'(pressed), 32'(ep));
    chk({tag, "_released"}, 32'(released), 32'(er));
    step();
    chk({tag, "_fv_pulse"}, 32'(frame_valid), 0);
  endtask

  initial begin
    int n;
    pat[0] = '0;
    pat[1] = '0;
    repeat (3) step();
    chk("rst_clklatch", 32'(clklatch), 0);
    chk("rst_clkout", 32'(clkout), 0);
    chk("rst_buttons", 32'(buttons), 0);
    chk("rst_pressed", 32'(pressed), 0);
    chk("rst_released", 32'(released), 0);
    chk("rst_fv", 32'(frame_valid), 0);

    rst_n = 1'b1;
    poll_en = 1'b1;
    pat[0] = 8'h81;
    expect_frame("f1");
    chk("f1_btn0", 32'(buttons[7:0]), 32'h81);
    chk("f1_pr0", 32'(last_pr[7:0]), 32'h81);

    expect_frame("f2");
    chk("f2_btn0", 32'(buttons[7:0]), 32'h81);
    chk("per_cycles", 32'(period_s), 81);
    chk("per_latch", 32'(latch_s), 8);
    chk("per_ck_rises", 32'(ckrise_s), 7);
    chk("per_ck_high", 32'(ckcyc_s), 28);

    pat[0] = 8'h80;
    pat[1] = 8'h10;
    expect_frame("f3");
    chk("f3_rel_a", 32'(last_rl[0]), 1);
    chk("f3_press_up", 32'(last_pr[12]), 1);

    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < NP; p++)
        pat[p] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      expect_frame("rnd");
    end

    // poll_en drop mid-frame: frame completes, then the poller idles.
    pat[0] = 8'h5a;
    pat[1] = 8'hc3;
    wait_latch("drop");
    poll_en = 1'b0;
    expect_frame("drop");
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (clklatch) n++;
    end
    chk("drop_idle_latch", 32'(n), 0);
    poll_en = 1'b1;

    // Reset in the middle of LATCH.
    wait_latch("rl");
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rl_clklatch", 32'(clklatch), 0);
    chk("rl_clkout", 32'(clkout), 0);
    chk("rl_buttons", 32'(buttons), 0);
    chk("rl_pressed", 32'(pressed), 0);
    chk("rl_released", 32'(released), 0);
    chk("rl_fv", 32'(frame_valid), 0);
    model_btn = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rl_idle_latch", 32'(clklatch), 0);
    wait_latch("rl2");
    n = 0;
    while (clklatch && n < 50) begin n++; step(); end
    chk("rl_latch_len", 32'(n), 8);
    expect_frame("rl_f");

    // Reset during READ of bit 3.
    n = 0;
    while (!(pidx == 3 && !clkout && !clklatch) && n < 400) begin step(); n++; end
    chk("rd3_find_timeout", 32'(n >= 400), 0);
    rst_n = 1'b0;
    pat[0] = 8'h81;
    pat[1] = 8'($urandom);
    model_btn = '0;
    step();
    step();
    rst_n = 1'b1;
    expect_frame("rd3");
    chk("rd3_btn0", 32'(buttons[7:0]), 32'h81);
    chk("rd3_pr0", 32'(last_pr[7:0]), 32'h81);

    chk("clkout_pulse_width", 32'(pulse_bad), 0);
    chk("strobe_idle", 32'(strobe_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
